// File: rtl/apb_req_arbiter.sv
// Arbitrates NUM_REQ bus requesters onto a single apb_controller_sbm instance.
// Define APB_ARB_RR_EN for round-robin; the default build uses fixed lowest-index priority.
package apb_arb_pkg;
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } cs_size;
endpackage

module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DAT_W   = 32,
    parameter int ADDR_W  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               dir_i,
    input  cs_size                           size_i [NUM_REQ],
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ-1:0][DAT_W-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               done_o,
    output logic                             err_o,
    output logic [DAT_W-1:0]                 rdata_o,
    output logic                             ctrl_start_o,
    output logic                             ctrl_dir_o,
    output cs_size                           ctrl_size_o,
    output logic [ADDR_W-1:0]                ctrl_addr_o,
    output logic [DAT_W-1:0]                 ctrl_wdata_o,
    input  logic                             ctrl_ready_i,
    input  logic                             ctrl_valid_i,
    input  logic                             ctrl_err_i,
    input  logic [DAT_W-1:0]                 ctrl_rdata_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 dir_q, dir_d;
    cs_size               size_q, size_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DAT_W-1:0]     wdata_q, wdata_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 start_q, start_d;
    logic                 err_q, err_d;
    logic [DAT_W-1:0]     rdata_q, rdata_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;

    // Sequencing relies only on ready; valid carries no extra information here.
    logic unused_valid;
    assign unused_valid = ctrl_valid_i;

`ifdef APB_ARB_RR_EN
    logic [IDX_W-1:0]     ptr_q, ptr_d;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + 1 + i) % NUM_REQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        start_d = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef APB_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // A busy controller (e.g. after an arbiter-only reset) blocks new grants.
                if (win_found && ctrl_ready_i) begin
                    state_d        = ISSUE;
                    idx_d          = win_idx;
                    dir_d          = dir_i[win_idx];
                    size_d         = size_i[win_idx];
                    addr_d         = addr_i[win_idx];
                    wdata_d        = wdata_i[win_idx];
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    start_d        = 1'b1;
`ifdef APB_ARB_RR_EN
                    ptr_d          = win_idx;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ctrl_ready_i) begin
                    state_d       = RESP;
                    rdata_d       = ctrl_rdata_i;
                    err_d         = ctrl_err_i;
                    done_d[idx_q] = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            size_q  <= SIZE_W;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef APB_ARB_RR_EN
            ptr_q   <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            start_q <= start_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef APB_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign rdata_o      = rdata_q;
    assign ctrl_start_o = start_q;
    assign ctrl_dir_o   = dir_q;
    assign ctrl_size_o  = size_q;
    assign ctrl_addr_o  = addr_q;
    assign ctrl_wdata_o = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a wait-state slave model and a completion scoreboard.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_i;
    logic [1:0]        dir_i;
    cs_size            size_i [2];
    logic [1:0][31:0]  addr_i;
    logic [1:0][31:0]  wdata_i;
    logic [1:0]        gnt_o;
    logic [1:0]        done_o;
    logic              err_o;
    logic [31:0]       rdata_o;
    logic              ctrl_start_o;
    logic              ctrl_dir_o;
    cs_size            ctrl_size_o;
    logic [31:0]       ctrl_addr_o;
    logic [31:0]       ctrl_wdata_o;
    logic              ctrl_ready_i = 1'b1;
    logic              ctrl_valid_i;
    logic              ctrl_err_i = 1'b0;
    logic [31:0]       ctrl_rdata_i = 32'h0;

    int                vec_cnt  = 0;
    int                miss_cnt = 0;
    bit                mon_en   = 1'b0;

    int                slave_waits = 0;
    logic              slave_err   = 1'b0;
    logic [31:0]       slave_base  = 32'h0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        bit          chk_rd;
    } sb_t;

    sb_t sb [$];
    sb_t mon_e;

    apb_req_arbiter #(.NUM_REQ(2), .DAT_W(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .dir_i        (dir_i),
        .size_i       (size_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .ctrl_start_o (ctrl_start_o),
        .ctrl_dir_o   (ctrl_dir_o),
        .ctrl_size_o  (ctrl_size_o),
        .ctrl_addr_o  (ctrl_addr_o),
        .ctrl_wdata_o (ctrl_wdata_o),
        .ctrl_ready_i (ctrl_ready_i),
        .ctrl_valid_i (ctrl_valid_i),
        .ctrl_err_i   (ctrl_err_i),
        .ctrl_rdata_i (ctrl_rdata_i)
    );

    always #5 clk = ~clk;

    assign ctrl_valid_i = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [31:0] rd, input logic err, input bit chk_rd);
        sb_t e;
        e.idx    = idx;
        e.rdata  = rd;
        e.err    = err;
        e.chk_rd = chk_rd;
        sb.push_back(e);
    endtask

    // Slave model: returns base ^ addr; holds ready low for slave_waits WAIT cycles.
    always @(negedge clk) begin
        if (ctrl_start_o === 1'b1) begin
            ctrl_rdata_i = slave_base ^ ctrl_addr_o;
            ctrl_err_i   = slave_err;
            if (slave_waits > 0) begin
                ctrl_ready_i = 1'b0;
                repeat (slave_waits + 1) @(negedge clk);
                ctrl_ready_i = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && done_o !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done_o), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_done_idx", 64'(done_o), 64'(2'b01 << mon_e.idx));
                chk("sb_err", 64'(err_o), 64'(mon_e.err));
                if (mon_e.chk_rd) chk("sb_rdata", 64'(rdata_o), 64'(mon_e.rdata));
            end
        end
    end

    initial begin
        int exp_order [4];

        rst       = 1'b1;
        req_i     = 2'b00;
        dir_i     = 2'b00;
        size_i[0] = SIZE_W;
        size_i[1] = SIZE_W;
        addr_i    = '0;
        wdata_i   = '0;

        // Reset state
        tick(2);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_start", 64'(ctrl_start_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_rdata", 64'(rdata_o), 64'd0);
        chk("rst_size", 64'(ctrl_size_o), 64'(SIZE_W));
        chk("rst_addr", 64'(ctrl_addr_o), 64'd0);
        chk("rst_wdata", 64'(ctrl_wdata_o), 64'd0);
        chk("rst_dir", 64'(ctrl_dir_o), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single read from requester 0, zero wait states
        slave_base  = 32'hDEADBEEF ^ 32'h0000_1000;
        slave_waits = 0;
        slave_err   = 1'b0;
        req_i       = 2'b01;
        dir_i       = 2'b00;
        addr_i[0]   = 32'h0000_1000;
        push(0, 32'hDEADBEEF, 1'b0, 1'b1);
        tick(1);
        chk("t1_c1_gnt", 64'(gnt_o), 64'h1);
        chk("t1_c1_start", 64'(ctrl_start_o), 64'h1);
        chk("t1_c1_addr", 64'(ctrl_addr_o), 64'h1000);
        chk("t1_c1_dir", 64'(ctrl_dir_o), 64'h0);
        req_i = 2'b00;
        tick(1);
        chk("t1_c2_gnt", 64'(gnt_o), 64'h1);
        chk("t1_c2_start", 64'(ctrl_start_o), 64'h0);
        chk("t1_c2_done", 64'(done_o), 64'h0);
        tick(1);
        chk("t1_c3_gnt", 64'(gnt_o), 64'h1);
        chk("t1_c3_done", 64'(done_o), 64'h1);
        chk("t1_c3_rdata", 64'(rdata_o), 64'hDEADBEEF);
        chk("t1_c3_err", 64'(err_o), 64'h0);
        tick(1);
        chk("t1_c4_gnt", 64'(gnt_o), 64'h0);
        chk("t1_c4_done", 64'(done_o), 64'h0);

        // Write from requester 1, SIZE_H, 3 wait states, payload changed after grant
        slave_waits = 3;
        req_i       = 2'b10;
        dir_i       = 2'b10;
        size_i[1]   = SIZE_H;
        addr_i[1]   = 32'h0000_2000;
        wdata_i[1]  = 32'h0000_1234;
        push(1, 32'h0, 1'b0, 1'b0);
        tick(1);
        chk("t2_c1_gnt", 64'(gnt_o), 64'h2);
        chk("t2_c1_start", 64'(ctrl_start_o), 64'h1);
        req_i      = 2'b00;
        dir_i      = 2'b00;
        size_i[1]  = SIZE_B;
        addr_i[1]  = 32'h0000_FFFF;
        wdata_i[1] = 32'h0000_0BAD;
        for (int c = 2; c <= 5; c++) begin
            tick(1);
            chk("t2_hold_addr", 64'(ctrl_addr_o), 64'h2000);
            chk("t2_hold_wdata", 64'(ctrl_wdata_o), 64'h1234);
            chk("t2_hold_size", 64'(ctrl_size_o), 64'(SIZE_H));
            chk("t2_hold_dir", 64'(ctrl_dir_o), 64'h1);
            chk("t2_hold_done", 64'(done_o), 64'h0);
        end
        tick(1);
        chk("t2_c6_done", 64'(done_o), 64'h2);
        tick(1);

        // Both requesters held for four back-to-back transactions
        slave_waits = 0;
        slave_base  = 32'h1111_0000;
        req_i       = 2'b11;
        dir_i       = 2'b00;
        addr_i[0]   = 32'h0000_0100;
        addr_i[1]   = 32'h0000_0200;
`ifdef APB_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int t = 0; t < 4; t++)
            push(exp_order[t], 32'h1111_0000 ^ (exp_order[t] == 0 ? 32'h100 : 32'h200), 1'b0, 1'b1);
        for (int t = 0; t < 4; t++) begin
            tick(1);
            chk("t3_gnt_order", 64'(gnt_o), 64'(2'b01 << exp_order[t]));
            chk("t3_start", 64'(ctrl_start_o), 64'h1);
            tick(3);
        end
        req_i = 2'b00;
        tick(1);
        chk("t3_idle_gnt", 64'(gnt_o), 64'h0);

        // Slave error on a read, then a clean read
        slave_waits = 1;
        slave_err   = 1'b1;
        req_i       = 2'b01;
        addr_i[0]   = 32'h0000_0300;
        push(0, 32'h1111_0300, 1'b1, 1'b1);
        tick(1);
        req_i = 2'b00;
        tick(3);
        chk("t4_err_done", 64'(done_o), 64'h1);
        chk("t4_err_set", 64'(err_o), 64'h1);
        slave_err   = 1'b0;
        slave_waits = 0;
        req_i       = 2'b01;
        push(0, 32'h1111_0300, 1'b0, 1'b1);
        tick(1);
        chk("t4_err_hold", 64'(err_o), 64'h1);
        chk("t4_idle_gnt", 64'(gnt_o), 64'h0);
        tick(1);
        chk("t4_c6_start", 64'(ctrl_start_o), 64'h1);
        chk("t4_c6_gnt", 64'(gnt_o), 64'h1);
        req_i = 2'b00;
        tick(2);
        chk("t4_clean_done", 64'(done_o), 64'h1);
        chk("t4_clean_err", 64'(err_o), 64'h0);
        tick(1);

        // Requester drops req and changes addr mid-transaction
        slave_waits = 2;
        req_i       = 2'b01;
        addr_i[0]   = 32'h0000_0400;
        push(0, 32'h1111_0400, 1'b0, 1'b1);
        tick(1);
        chk("t5_c1_addr", 64'(ctrl_addr_o), 64'h400);
        tick(1);
        req_i     = 2'b00;
        addr_i[0] = 32'h0000_9999;
        tick(1);
        chk("t5_c3_addr", 64'(ctrl_addr_o), 64'h400);
        tick(1);
        chk("t5_c4_addr", 64'(ctrl_addr_o), 64'h400);
        chk("t5_c4_done", 64'(done_o), 64'h0);
        tick(1);
        chk("t5_c5_done", 64'(done_o), 64'h1);
        chk("t5_c5_addr", 64'(ctrl_addr_o), 64'h400);
        tick(1);

        // Reset in WAIT with the controller still busy
        slave_waits = 10;
        req_i       = 2'b01;
        addr_i[0]   = 32'h0000_0500;
        tick(1);
        chk("t6_c1_start", 64'(ctrl_start_o), 64'h1);
        req_i = 2'b00;
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_gnt", 64'(gnt_o), 64'h0);
        chk("t6_rst_start", 64'(ctrl_start_o), 64'h0);
        chk("t6_rst_done", 64'(done_o), 64'h0);
        chk("t6_rst_rdata", 64'(rdata_o), 64'h0);
        rst   = 1'b0;
        req_i = 2'b01;
        push(0, 32'h1111_0500, 1'b0, 1'b1);
        tick(1);
        slave_waits = 0;
        for (int c = 5; c <= 12; c++) begin
            chk("t6_blocked_start", 64'(ctrl_start_o), 64'h0);
            chk("t6_blocked_gnt", 64'(gnt_o), 64'h0);
            chk("t6_blocked_done", 64'(done_o), 64'h0);
            tick(1);
        end
        chk("t6_c13_start", 64'(ctrl_start_o), 64'h1);
        chk("t6_c13_gnt", 64'(gnt_o), 64'h1);
        req_i = 2'b00;
        tick(2);
        chk("t6_c15_done", 64'(done_o), 64'h1);
        tick(3);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Shares one `apb_controller_sbm` instance between `NUM_REQ` bus requesters, e.g. instruction fetch, load/store and debug. It selects one pending request and latches its payload. It then sequences the controller's start/complete handshake and returns read data and error status to the selected requester with a one-cycle done pulse. It sits between the core's memory-side requesters and the single APB controller.

## Interface
**Parameters**
- `NUM_REQ`, default 2: number of requesters, at least 2.
- `DAT_W`, default 32: data width.
- `ADDR_W`, default 32: address width.

**Ports**
- `clk`  in  1: the single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_i`  in  NUM_REQ: per-requester transaction request.
- `dir_i`  in  NUM_REQ: per-requester direction, 0 = read, 1 = write.
- `size_i`  in  NUM_REQ x cs_size: per-requester write size (SIZE_W, SIZE_H, SIZE_B).
- `addr_i`  in  NUM_REQ x ADDR_W: per-requester address.
- `wdata_i`  in  NUM_REQ x DAT_W: per-requester write data.
- `gnt_o`  out  NUM_REQ: one-hot grant.
- `done_o`  out  NUM_REQ: one-hot completion pulse.
- `err_o`  out  1: slave error for the completing transaction; valid with `done_o`.
- `rdata_o`  out  DAT_W: read data; valid with `done_o`.
- `ctrl_start_o`  out  1: drives the controller's `start_i`.
- `ctrl_dir_o`  out  1: drives the controller's `dir_i`.
- `ctrl_size_o`  out  cs_size: drives the controller's `write_size_i`.
- `ctrl_addr_o`  out  ADDR_W: drives the controller's `addr_i`.
- `ctrl_wdata_o`  out  DAT_W: drives the controller's `wdata_i`.
- `ctrl_ready_i`  in  1: the controller's `ready_o`.
- `ctrl_valid_i`  in  1: the controller's `valid_o`.
- `ctrl_err_i`  in  1: the controller's `err_o`.
- `ctrl_rdata_i`  in  DAT_W: the controller's `rdata_o`.

## Operation
**States:** IDLE, ISSUE, WAIT, RESP.

**IDLE**
- If any `req_i` bit is set and `ctrl_ready_i` = 1:
  - pick a winner per the Configuration policy;
  - latch its index, dir, size, addr and wdata into payload registers;
  - go to ISSUE.
- If `ctrl_ready_i` = 0, no grant is made. This covers the case where the controller is still finishing a transfer after an arbiter-only reset.

**ISSUE**
- `ctrl_start_o` = 1 for exactly one cycle; go to WAIT.

**WAIT**
- Leave when `ctrl_ready_i` = 1.
- Capture `ctrl_rdata_i` into the `rdata_o` register.
- Capture `ctrl_err_i` into the `err_o` register.
- Go to RESP.

**RESP**
- `done_o[idx]` = 1 for one cycle; go to IDLE.

**Outputs and payload**
- `ctrl_dir_o`, `ctrl_size_o`, `ctrl_addr_o` and `ctrl_wdata_o` always come from the payload registers, so they are stable from ISSUE through WAIT. The controller drives APB address and data combinationally and relies on this.
- `gnt_o[idx]` = 1 in ISSUE, WAIT and RESP, and 0 in IDLE.
- The requester may drop `req_i` or change its payload once `gnt_o` is seen. The latched transaction still completes and `done_o` still pulses.
- A requester that keeps `req_i` high after `done_o` re-enters arbitration in the next IDLE cycle.
- `rdata_o` and `err_o` hold their value until the next WAIT capture.
- `ctrl_valid_i` is unused for sequencing; error is reported via `err_o`. On writes, `rdata_o` holds the captured value, which is don't-care.

**Reset** (all registers, synchronous)
- State = IDLE.
- `gnt_o`, `done_o` and `ctrl_start_o` = 0.
- `err_o` = 0, `rdata_o` = 0.
- Payload registers = 0, with `ctrl_size_o` = SIZE_W.
- Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-transaction:
  - the transaction is dropped with no `done_o`;
  - after reset, the arbiter waits in IDLE for `ctrl_ready_i` before issuing.

## Timing
- Zero-wait-state slave, `req_i[k]` rising at cycle 0 with the arbiter in IDLE:
  - cycle 1: ISSUE, `ctrl_start_o`;
  - cycle 2: WAIT, `ctrl_ready_i` = 1;
  - cycle 3: RESP, `done_o[k]`.
  - Total: 3 cycles from request to done.
- Each slave wait state adds 1 cycle.
- The next grant is made at the earliest in the cycle after RESP. Back-to-back throughput is one transaction per 4 cycles.
- `gnt_o` and `done_o` are registered outputs. `ctrl_*` outputs are registered with no combinational paths from `req_i`.

## Configuration
- `APB_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at the index after the last granted one and wraps at NUM_REQ-1 back to 0.
  - The pointer updates to the granted index on every grant.
- `APB_ARB_RR_EN` undefined: fixed priority; the lowest set index always wins.
  - The pointer register is not implemented.

## Test plan
- Single read, requester 0, addr 0x1000, slave returns 0xDEADBEEF with no wait states -> `gnt_o` = 01 in cycles 1–3, `ctrl_start_o` high only in cycle 1, `done_o` = 01 in cycle 3, `rdata_o` = 0xDEADBEEF, `err_o` = 0.
- Write from requester 1, size SIZE_H, wdata 0x1234, slave inserts 3 wait states -> `ctrl_addr_o`, `ctrl_wdata_o` and `ctrl_size_o` stay constant through WAIT; `done_o` = 10 at cycle 6.
- `req_i` = 11 held continuously for 4 transactions:
  - with `APB_ARB_RR_EN`: grant order 0, 1, 0, 1;
  - without it: 0, 0, 0, 0.
- Slave asserts pslverr on a read -> `err_o` = 1 coincident with `done_o`; the next transaction reports `err_o` = 0.
- Requester 0 drops `req_i` and changes addr in cycle 2 of its transaction -> the original addr is held and `done_o[0]` still pulses.
- `rst` asserted in WAIT while `ctrl_ready_i` = 0 -> no `done_o`; state = IDLE; no `ctrl_start_o` until `ctrl_ready_i` = 1.
